// File: rtl/l2_pkg.sv
// Shared constants and types for the L2 request arbiter.
// Widths, FSM state encoding and L1 port ids.
package l2_pkg;

  localparam int ADDRW = 28;
  localparam int DATAW = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational grant choice between I-side and D-side requests.
// L2ARB_DPORT_PRIO_EN: D wins every tie; otherwise round-robin.
module l2_arb_pick
  import l2_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // pick a winner; ties resolved by priority or by last grant
  always_comb begin
    grant_valid = req_i | req_d;
    grant_id    = PORT_I;
    unique case (1'b1)
      (req_i & req_d): begin
`ifdef L2ARB_DPORT_PRIO_EN
        grant_id = PORT_D;
`else
        grant_id = ~last_grant;
`endif
      end
      (req_d & ~req_i): grant_id = PORT_D;
      (req_i & ~req_d): grant_id = PORT_I;
      default:          grant_id = PORT_I;
    endcase
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares one L2 request port between the I-side and D-side L1s.
// Tie policy selected by L2ARB_DPORT_PRIO_EN (see l2_arb_pick).
module l2_arbiter
  import l2_pkg::*;
(
  input  logic             clk,
  input  logic             proc_reset_n,
  input  logic             I_read,
  input  logic             I_write,
  input  logic [ADDRW-1:0] I_addr,
  input  logic [DATAW-1:0] I_wdata,
  output logic [DATAW-1:0] I_rdata,
  output logic             I_ready,
  input  logic             D_read,
  input  logic             D_write,
  input  logic [ADDRW-1:0] D_addr,
  input  logic [DATAW-1:0] D_wdata,
  output logic [DATAW-1:0] D_rdata,
  output logic             D_ready,
  output logic             L2_read,
  output logic             L2_write,
  output logic [ADDRW-1:0] L2_addr,
  output logic [DATAW-1:0] L2_wdata,
  input  logic [DATAW-1:0] L2_rdata,
  input  logic             L2_ready
);

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic             lat_rd;
  logic             lat_wr;
  logic [ADDRW-1:0] lat_addr;
  logic [DATAW-1:0] lat_wdata;
  logic             req_i;
  logic             req_d;
  logic             grant_valid;
  logic             grant_id;
  logic             take;

  // read&write together is illegal and counts as no request
  assign req_i = I_read ^ I_write;
  assign req_d = D_read ^ D_write;

  l2_arb_pick u_pick (
    .req_i       (req_i),
    .req_d       (req_d),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign take     = (state == IDLE) & grant_valid;
  assign L2_addr  = lat_addr;
  assign L2_wdata = lat_wdata;

  // next state, L2 request from latch, return routing
  always_comb begin
    state_nx = state;
    L2_read  = 1'b0;
    L2_write = 1'b0;
    I_ready  = 1'b0;
    D_ready  = 1'b0;
    I_rdata  = '0;
    D_rdata  = '0;
    unique case (state)
      IDLE: begin
        if (grant_valid)
          state_nx = (grant_id == PORT_D) ? BUSY_D : BUSY_I;
      end
      BUSY_I: begin
        L2_read  = lat_rd;
        L2_write = lat_wr;
        if (L2_ready) begin
          I_ready  = 1'b1;
          I_rdata  = lat_rd ? L2_rdata : '0;
          state_nx = IDLE;
        end
      end
      BUSY_D: begin
        L2_read  = lat_rd;
        L2_write = lat_wr;
        if (L2_ready) begin
          D_ready  = 1'b1;
          D_rdata  = lat_rd ? L2_rdata : '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, grant history and request latch
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state      <= IDLE;
      last_grant <= PORT_I;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        last_grant <= grant_id;
        if (grant_id == PORT_D) begin
          lat_rd    <= D_read;
          lat_wr    <= D_write;
          lat_addr  <= D_addr;
          lat_wdata <= D_wdata;
        end else begin
          lat_rd    <= I_read;
          lat_wr    <= I_write;
          lat_addr  <= I_addr;
          lat_wdata <= I_wdata;
        end
      end
    end
  end

endmodule
